// File: rtl/multi_cycle_cpu_hs.sv
// Multi-cycle MIPS-32 core with a req/ready memory handshake, an external register file,
// alignment/illegal-opcode trap and a retired-instruction counter.
module multi_cycle_cpu_hs #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter bit          STRICT_ALIGN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            memAddr,
    output logic                   memReq,
    output logic                   memWe,
    output logic [31:0]            memWriteData,
    input  logic [31:0]            memReadData,
    input  logic                   memReady,
    output logic [4:0]             regReadAddr1,
    output logic [4:0]             regReadAddr2,
    input  logic [31:0]            regReadData1,
    input  logic [31:0]            regReadData2,
    output logic                   regWrite,
    output logic [4:0]             regWriteAddr,
    output logic [31:0]            regWriteData,
    output logic [31:0]            pcOut,
    output logic [31:0]            instruction,
    output logic [3:0]             state,
    output logic                   trap,
    output logic                   retired,
    output logic [COUNT_WIDTH-1:0] retireCount
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_READ = 4'd3,
        MEM_WB    = 4'd4,  MEM_WRITE = 4'd5, EXEC_R = 4'd6,  R_WB = 4'd7,
        BRANCH    = 4'd8,  JUMP = 4'd9,    EXEC_I = 4'd10,   I_WB = 4'd11,
        JAL       = 4'd12, JR = 4'd13,     TRAP = 4'd15
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW   = 6'h2b;
    localparam logic [5:0] F_JR  = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2a;

    // A misaligned reset vector must not issue a fetch; it traps out of FETCH instead.
    localparam bit RESET_REQ = !(STRICT_ALIGN && (RESET_PC[1:0] != 2'b00));

    stateT       fsm;
    logic [31:0] pc, ir, a, b, aluOut;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd;
    logic [15:0] imm;
    logic [31:0] sextImm, zextImm, aluResult, effAddr, memEa, jumpTarget, fetchTarget;
    logic        takeBranch, retiring, fetchMisaligned, pcMisaligned, memAlignBad;

    assign opcode     = ir[31:26];
    assign rt         = ir[20:16];
    assign rd         = ir[15:11];
    assign funct      = ir[5:0];
    assign imm        = ir[15:0];
    assign sextImm    = {{16{imm[15]}}, imm};
    assign zextImm    = {16'h0000, imm};
    assign jumpTarget = {pc[31:28], ir[25:0], 2'b00};
    assign effAddr    = a + sextImm;
    assign memEa      = STRICT_ALIGN ? effAddr : {effAddr[31:2], 2'b00};
    assign memAlignBad  = STRICT_ALIGN && (effAddr[1:0] != 2'b00);
    assign pcMisaligned = STRICT_ALIGN && (pc[1:0] != 2'b00);
    assign takeBranch   = (opcode == OP_BEQ) ? (a == b) : (a != b);

    assign regReadAddr1 = ir[25:21];
    assign regReadAddr2 = ir[20:16];
    assign pcOut        = pc;
    assign instruction  = ir;
    assign state        = fsm;
    assign retired      = retiring;

    // Shared ALU: R-type by funct, I-type by opcode.
    always_comb begin
        aluResult = a + b;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_SUB:   aluResult = a - b;
                F_AND:   aluResult = a & b;
                F_OR:    aluResult = a | b;
                F_SLT:   aluResult = {31'b0, $signed(a) < $signed(b)};
                default: aluResult = a + b;
            endcase
        end else begin
            case (opcode)
                OP_ANDI: aluResult = a & zextImm;
                OP_ORI:  aluResult = a | zextImm;
                OP_SLTI: aluResult = {31'b0, $signed(a) < $signed(sextImm)};
                OP_LUI:  aluResult = {imm, 16'h0000};
                default: aluResult = a + sextImm;
            endcase
        end
    end

    // Retirement happens on the edge that returns to FETCH; compute where FETCH will point.
    always_comb begin
        retiring    = 1'b0;
        fetchTarget = pc;
        case (fsm)
            MEM_WB, R_WB, I_WB: retiring = 1'b1;
            MEM_WRITE:          retiring = memReady;
            BRANCH: begin
                retiring    = 1'b1;
                fetchTarget = takeBranch ? aluOut : pc;
            end
            JUMP, JAL: begin
                retiring    = 1'b1;
                fetchTarget = jumpTarget;
            end
            JR: begin
                retiring    = 1'b1;
                fetchTarget = a;
            end
            default: ;
        endcase
        fetchMisaligned = STRICT_ALIGN && (fetchTarget[1:0] != 2'b00);
    end

    // regWriteData doubles as the MDR on the load path.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= FETCH;
            pc           <= RESET_PC;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            aluOut       <= '0;
            memAddr      <= RESET_PC;
            memReq       <= RESET_REQ;
            memWe        <= 1'b0;
            memWriteData <= '0;
            regWrite     <= 1'b0;
            regWriteAddr <= '0;
            regWriteData <= '0;
            trap         <= 1'b0;
            retireCount  <= '0;
        end else begin
            regWrite <= 1'b0;
            case (fsm)
                FETCH: begin
                    if (pcMisaligned) begin
                        fsm    <= TRAP;
                        trap   <= 1'b1;
                        memReq <= 1'b0;
                    end else if (memReady) begin
                        ir     <= memReadData;
                        pc     <= pc + 32'd4;
                        memReq <= 1'b0;
                        fsm    <= DECODE;
                    end
                end
                DECODE: begin
                    a      <= regReadData1;
                    b      <= regReadData2;
                    aluOut <= pc + (sextImm << 2);
                    case (opcode)
                        OP_RTYPE: begin
                            case (funct)
                                F_ADD, F_SUB, F_AND, F_OR, F_SLT: fsm <= EXEC_R;
                                F_JR:    fsm <= JR;
                                default: begin
                                    fsm  <= TRAP;
                                    trap <= 1'b1;
                                end
                            endcase
                        end
                        OP_LW, OP_SW:   fsm <= MEM_ADDR;
                        OP_BEQ, OP_BNE: fsm <= BRANCH;
                        OP_J:           fsm <= JUMP;
                        OP_JAL: begin
                            fsm          <= JAL;
                            regWrite     <= 1'b1;
                            regWriteAddr <= 5'd31;
                            regWriteData <= pc;
                        end
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: fsm <= EXEC_I;
                        default: begin
                            fsm  <= TRAP;
                            trap <= 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    aluOut <= memEa;
                    if (memAlignBad) begin
                        fsm  <= TRAP;
                        trap <= 1'b1;
                    end else begin
                        memAddr      <= memEa;
                        memReq       <= 1'b1;
                        memWe        <= (opcode == OP_SW);
                        memWriteData <= b;
                        fsm          <= (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (memReady) begin
                        memReq       <= 1'b0;
                        regWrite     <= (rt != 5'd0);
                        regWriteAddr <= rt;
                        regWriteData <= memReadData;
                        fsm          <= MEM_WB;
                    end
                end
                EXEC_R: begin
                    aluOut       <= aluResult;
                    regWrite     <= (rd != 5'd0);
                    regWriteAddr <= rd;
                    regWriteData <= aluResult;
                    fsm          <= R_WB;
                end
                EXEC_I: begin
                    aluOut       <= aluResult;
                    regWrite     <= (rt != 5'd0);
                    regWriteAddr <= rt;
                    regWriteData <= aluResult;
                    fsm          <= I_WB;
                end
                MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, I_WB, JAL, JR, TRAP: ;
                default: begin
                    fsm  <= TRAP;
                    trap <= 1'b1;
                end
            endcase
            if (retiring) begin
                fsm         <= FETCH;
                pc          <= fetchTarget;
                memAddr     <= fetchTarget;
                memReq      <= !fetchMisaligned;
                memWe       <= 1'b0;
                retireCount <= retireCount + COUNT_WIDTH'(1);
            end
        end
    end

endmodule
